// File: rtl/core_pkg.sv
// Shared jacaranda-8 core types: address/instruction widths, fetch entries and redirects.
package core_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 8;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
  } redirect_t;

  typedef enum logic {
    StFlush,
    StStream
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} FIFO with synchronous clear and a registered head that
// holds its last value while the FIFO is empty.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head_q, head_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign head    = head_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // New head may be the entry being written this very cycle.
      if (count_d != '0) begin
        head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// jacaranda-8 fetch stage: PC, FLUSH/STREAM control and accepted-instruction
// counter around a fetch_fifo feeding decode.
module instr_fetch
  import core_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [15:0]        fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       count_q, count_d;
  redirect_t         redir;
  fetch_entry_t      wdata, head;
  logic              full, empty, push, pop;

  assign redir.valid = redirect_valid;
  assign redir.pc    = redirect_pc;

  // full is registered, so out_ready has no path to push or imem_addr.
  assign push = run & ~full & ~redir.valid;
  assign pop  = out_valid & out_ready & ~redir.valid;

  assign wdata.pc    = pc_q;
  assign wdata.instr = imem_instr;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .clear(redir.valid),
    .push (push),
    .wdata(wdata),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StFlush;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = StStream;
    if (redir.valid) state_d = StFlush;
  end

  always_comb begin
    out_valid = (state_q == StStream) & ~empty;
    out_pc    = head.pc;
    out_instr = head.instr;
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (redir.valid) pc_d = redir.pc;
    else if (push)   pc_d = pc_q + 1'b1;
    if (pop && (count_q != 16'hFFFF)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand sequences and random
// traffic compared against a queue-based reference of the fetch stage.
module tb_instr_fetch;
  import core_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        out_ready = 1'b0;
  logic [7:0]  imem_addr, imem_instr, out_instr, out_pc;
  logic        out_valid;
  logic [15:0] fetch_count;

  logic [7:0] rom [256];
  assign imem_instr = rom[imem_addr];

  always #5 clock = ~clock;

  instr_fetch #(
    .DEPTH   (DEPTH),
    .RESET_PC(8'h00)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_count   (fetch_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: a queue of buffered {pc, instr}, the fetch PC, the accepted count,
  // and whatever decode last saw at the head.
  fetch_entry_t m_q[$];
  logic [7:0]   m_pc;
  logic [15:0]  m_cnt;
  fetch_entry_t m_held;

  typedef struct {
    bit          rst;
    bit          run;
    bit          rv;
    logic [7:0]  rpc;
    bit          rdy;
    bit          ev;
    logic [7:0]  epc;
    logic [7:0]  ei;
    logic [15:0] ecnt;
    logic [7:0]  eaddr;
  } vec_t;

  vec_t       tbl [16];
  logic [7:0] wrap_exp [4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = 8'h00;
    m_cnt  = 16'h0000;
    m_held = '0;
  endtask

  task automatic model_step(input bit r, input bit rv, input logic [7:0] rpc, input bit rdy);
    bit was_full;
    bit had;
    fetch_entry_t e;
    if (rv) begin
      m_q.delete();
      m_pc = rpc;
    end else begin
      was_full = (m_q.size() == DEPTH);
      had      = (m_q.size() != 0);
      e.pc     = m_pc;
      e.instr  = rom[m_pc];
      if (had && rdy) begin
        m_q.delete(0);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (r && !was_full) begin
        m_q.push_back(e);
        m_pc = m_pc + 8'd1;
      end
    end
    if (m_q.size() != 0) m_held = m_q[0];
  endtask

  // Drive one cycle of inputs, clock it, update the reference, settle.
  task automatic cycle(input bit r, input bit rv, input logic [7:0] rpc, input bit rdy);
    run            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clock);
    model_step(r, rv, rpc, rdy);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 16'(out_valid), 16'(m_q.size() != 0));
    chk({tag, ".pc"}, 16'(out_pc), 16'(m_held.pc));
    chk({tag, ".instr"}, 16'(out_instr), 16'(m_held.instr));
    chk({tag, ".count"}, fetch_count, m_cnt);
    chk({tag, ".addr"}, 16'(imem_addr), 16'(m_pc));
  endtask

  // Assert reset between clock edges, check immediate effect, release on negedge.
  task automatic mid_reset();
    #1;
    reset          = 1'b0;
    run            = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    model_reset();
    #1;
    chk("rst.valid", 16'(out_valid), 16'h0);
    chk("rst.pc", 16'(out_pc), 16'h0);
    chk("rst.instr", 16'(out_instr), 16'h0);
    chk("rst.count", fetch_count, 16'h0);
    chk("rst.addr", 16'(imem_addr), 16'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    rom[0] = 8'hC0;
    rom[1] = 8'hD7;
    rom[2] = 8'h03;
    rom[3] = 8'hC0;

    //          rst run rv rpc    rdy  ev epc    ei     ecnt    eaddr
    tbl[0]  = '{1, 1, 0, 8'h00, 1,   1, 8'h00, 8'hC0, 16'd0, 8'h01};
    tbl[1]  = '{0, 1, 0, 8'h00, 1,   1, 8'h01, 8'hD7, 16'd1, 8'h02};
    tbl[2]  = '{0, 1, 0, 8'h00, 1,   1, 8'h02, 8'h03, 16'd2, 8'h03};
    tbl[3]  = '{0, 1, 0, 8'h00, 1,   1, 8'h03, 8'hC0, 16'd3, 8'h04};
    tbl[4]  = '{0, 1, 0, 8'h00, 1,   1, 8'h04, 8'h1F, 16'd4, 8'h05};
    tbl[5]  = '{1, 1, 0, 8'h00, 0,   1, 8'h00, 8'hC0, 16'd0, 8'h01};
    tbl[6]  = '{0, 1, 0, 8'h00, 0,   1, 8'h00, 8'hC0, 16'd0, 8'h02};
    tbl[7]  = '{0, 1, 0, 8'h00, 0,   1, 8'h00, 8'hC0, 16'd0, 8'h02};
    tbl[8]  = '{0, 1, 0, 8'h00, 0,   1, 8'h00, 8'hC0, 16'd0, 8'h02};
    tbl[9]  = '{0, 1, 0, 8'h00, 0,   1, 8'h00, 8'hC0, 16'd0, 8'h02};
    tbl[10] = '{0, 1, 0, 8'h00, 1,   1, 8'h01, 8'hD7, 16'd1, 8'h02};
    tbl[11] = '{0, 1, 0, 8'h00, 1,   1, 8'h02, 8'h03, 16'd2, 8'h03};
    tbl[12] = '{0, 1, 0, 8'h00, 1,   1, 8'h03, 8'hC0, 16'd3, 8'h04};
    tbl[13] = '{0, 1, 1, 8'h14, 1,   0, 8'h03, 8'hC0, 16'd3, 8'h14};
    tbl[14] = '{0, 1, 0, 8'h00, 1,   1, 8'h14, 8'h8F, 16'd3, 8'h15};
    tbl[15] = '{0, 1, 0, 8'h00, 1,   1, 8'h15, 8'h96, 16'd4, 8'h16};

    // Initial reset
    mid_reset();

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) mid_reset();
      cycle(tbl[i].run, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), 16'(out_valid), 16'(tbl[i].ev));
      chk($sformatf("tbl%0d.pc", i), 16'(out_pc), 16'(tbl[i].epc));
      chk($sformatf("tbl%0d.instr", i), 16'(out_instr), 16'(tbl[i].ei));
      chk($sformatf("tbl%0d.count", i), fetch_count, tbl[i].ecnt);
      chk($sformatf("tbl%0d.addr", i), 16'(imem_addr), 16'(tbl[i].eaddr));
    end

    // Redirect while two entries are buffered and decode is ready
    mid_reset();
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    check_model("fill");
    cycle(1, 1, 8'h14, 1);
    chk("redir.valid", 16'(out_valid), 16'h0);
    chk("redir.count", fetch_count, 16'h0);
    chk("redir.addr", 16'(imem_addr), 16'h14);
    cycle(1, 0, 8'h00, 1);
    chk("redir.tgt_valid", 16'(out_valid), 16'h1);
    chk("redir.tgt_pc", 16'(out_pc), 16'h14);
    chk("redir.tgt_instr", 16'(out_instr), 16'(rom[8'h14]));
    check_model("redir");

    // PC wrap from FE through 01 with continuous valid
    wrap_exp[0] = 8'hFE;
    wrap_exp[1] = 8'hFF;
    wrap_exp[2] = 8'h00;
    wrap_exp[3] = 8'h01;
    cycle(1, 1, 8'hFE, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 8'h00, 1);
      chk($sformatf("wrap%0d.valid", i), 16'(out_valid), 16'h1);
      chk($sformatf("wrap%0d.pc", i), 16'(out_pc), 16'(wrap_exp[i]));
      check_model($sformatf("wrap%0d", i));
    end

    // run=0: drain buffered entries, PC holds, redirect still loads
    mid_reset();
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 8'h00, 1);
      check_model($sformatf("drain%0d", i));
    end
    chk("drain.valid", 16'(out_valid), 16'h0);
    chk("drain.addr", 16'(imem_addr), 16'h02);
    chk("drain.count", fetch_count, 16'd2);
    cycle(0, 1, 8'h1B, 0);
    chk("idle_redir.addr", 16'(imem_addr), 16'h1B);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 8'h00, 1);
      chk($sformatf("idle%0d.valid", i), 16'(out_valid), 16'h0);
      chk($sformatf("idle%0d.addr", i), 16'(imem_addr), 16'h1B);
    end
    cycle(1, 0, 8'h00, 1);
    chk("resume.pc", 16'(out_pc), 16'h1B);
    check_model("resume");

    // Reset in the middle of streaming, then resume from 00
    cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    mid_reset();
    cycle(1, 0, 8'h00, 1);
    chk("postrst.pc", 16'(out_pc), 16'h00);
    check_model("postrst");

    // Random traffic against the reference
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) mid_reset();
      cycle($urandom_range(3) != 0, $urandom_range(9) == 0, 8'($urandom),
            $urandom_range(4) < 3);
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
